// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared funct3 encodings and FSM state type for the sub-word LSU
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } lsu_state_e;

endpackage

// File: rtl/lsu_subword_if.sv
// rtl/lsu_subword_if.sv - core request/response and word memory port bundle
interface lsu_subword_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [2:0]            req_funct3;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [31:0]           req_wdata;
  logic                  rsp_valid;
  logic [31:0]           rsp_rdata;
  logic                  rsp_err;
  logic                  mem_read;
  logic                  mem_write;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wdata;
  logic [31:0]           mem_rdata;

  // master: the core plus the memory it fronts; slave: the LSU itself
  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
           mem_read, mem_write, mem_addr, mem_wdata
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - lane extract/extend, store merge and request legality check
module lsu_align
  import lsu_pkg::*;
(
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rword,
  input  logic [15:0] sdata,
  output logic [31:0] ldata,
  output logic [31:0] merged,
  output logic        err
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic        illegal;
  logic        misaligned;

  always_comb begin
    lane_b = rword[7:0];
    case (addr_lo)
      2'd0: lane_b = rword[7:0];
      2'd1: lane_b = rword[15:8];
      2'd2: lane_b = rword[23:16];
      2'd3: lane_b = rword[31:24];
      default: lane_b = rword[7:0];
    endcase
    lane_h = addr_lo[1] ? rword[31:16] : rword[15:0];

    ldata = '0;
    case (funct3)
      F3_B:    ldata = {{24{lane_b[7]}}, lane_b};
      F3_H:    ldata = {{16{lane_h[15]}}, lane_h};
      F3_W:    ldata = rword;
      F3_BU:   ldata = {24'h0, lane_b};
      F3_HU:   ldata = {16'h0, lane_h};
      default: ldata = '0;
    endcase

    // Only the addressed lane is replaced; every other bit comes from the read word.
    merged = rword;
    if (funct3 == F3_B) begin
      case (addr_lo)
        2'd0: merged[7:0]   = sdata[7:0];
        2'd1: merged[15:8]  = sdata[7:0];
        2'd2: merged[23:16] = sdata[7:0];
        2'd3: merged[31:24] = sdata[7:0];
        default: merged = rword;
      endcase
    end else if (funct3 == F3_H) begin
      if (addr_lo[1]) merged[31:16] = sdata;
      else            merged[15:0]  = sdata;
    end

    if (we) illegal = !(funct3 == F3_B || funct3 == F3_H || funct3 == F3_W);
    else    illegal = (funct3 == 3'd3 || funct3 == 3'd6 || funct3 == 3'd7);

    misaligned = ((funct3 == F3_H || funct3 == F3_HU) && addr_lo[0]) ||
                 (funct3 == F3_W && addr_lo != 2'b00);

    err = illegal || misaligned;
  end

endmodule

// File: rtl/lsu_subword.sv
// rtl/lsu_subword.sv - byte/half/word load-store unit with read-modify-write sub-word stores
module lsu_subword
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  lsu_subword_if.slave bus
);

  lsu_state_e            state;
  logic                  we_q;
  logic [2:0]            f3_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [15:0]           wdata_q;
  logic [31:0]           word_buf;
  logic [31:0]           rsp_rdata_q;
  logic                  rsp_err_q;

  logic                  cur_we;
  logic [2:0]            cur_f3;
  logic [1:0]            cur_addr_lo;
  logic [31:0]           ldata;
  logic [31:0]           merged;
  logic                  chk_err;

  // Legality is judged on the live request in IDLE, on the latched copy afterwards.
  assign cur_we      = (state == IDLE) ? bus.req_we         : we_q;
  assign cur_f3      = (state == IDLE) ? bus.req_funct3     : f3_q;
  assign cur_addr_lo = (state == IDLE) ? bus.req_addr[1:0]  : addr_q[1:0];

  lsu_align u_align (
    .we      (cur_we),
    .funct3  (cur_f3),
    .addr_lo (cur_addr_lo),
    .rword   (bus.mem_rdata),
    .sdata   (wdata_q),
    .ldata   (ldata),
    .merged  (merged),
    .err     (chk_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      we_q        <= 1'b0;
      f3_q        <= 3'd0;
      addr_q      <= '0;
      wdata_q     <= 16'h0;
      word_buf    <= 32'h0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            we_q    <= bus.req_we;
            f3_q    <= bus.req_funct3;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata[15:0];
            if (chk_err) begin
              rsp_rdata_q <= 32'h0;
              rsp_err_q   <= 1'b1;
              state       <= RESP;
            end else if (bus.req_we && bus.req_funct3 == F3_W) begin
              word_buf <= bus.req_wdata;
              state    <= WRITE;
            end else begin
              state <= READ;
            end
          end
        end
        READ: begin
          if (we_q) begin
            word_buf <= merged;
            state    <= WRITE;
          end else begin
            rsp_rdata_q <= ldata;
            rsp_err_q   <= 1'b0;
            state       <= RESP;
          end
        end
        WRITE: begin
          rsp_rdata_q <= 32'h0;
          rsp_err_q   <= 1'b0;
          state       <= RESP;
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = (state == IDLE);
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.mem_read  = (state == READ);
  assign bus.mem_write = (state == WRITE);
  assign bus.mem_addr  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
  assign bus.mem_wdata = word_buf;

endmodule

// File: doc/lsu_subword.md
# lsu_subword

Load/store unit sitting between the single-cycle core's execute stage and the word-only data memory port. It is the initiator side of the memory interface: it drives `mem_read`, `mem_write`, `mem_addr` and `mem_wdata`, and consumes `mem_rdata`. It adds RV32 byte and halfword loads and stores (LB/LH/LBU/LHU/SB/SH) on top of word access, using read-modify-write for sub-word stores. A multi-cycle FSM with a valid/ready request side stalls the core while an access is in flight.

## Interface
- `ADDR_WIDTH`, 32: byte-address width of `req_addr` / `mem_addr`.
- `clk` in 1: system clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: core presents an access.
- `req_ready` out 1: high only in IDLE; a request is accepted on an edge where `req_valid && req_ready`.
- `req_we` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: RV32 funct3 (0 B, 1 H, 2 W, 4 BU, 5 HU).
- `req_addr` in ADDR_WIDTH: byte address.
- `req_wdata` in 32: store data (rs2); the low byte or half is used for SB/SH.
- `rsp_valid` out 1: one-cycle pulse when the access completes.
- `rsp_rdata` out 32: extended load data; 0 for stores and errors.
- `rsp_err` out 1: qualified by `rsp_valid`; misaligned address or illegal funct3.
- `mem_read` out 1: word read strobe (memory reads asynchronously).
- `mem_write` out 1: word write strobe (memory writes on the rising edge).
- `mem_addr` out ADDR_WIDTH: word-aligned address, `{addr[ADDR_WIDTH-1:2],2'b00}`.
- `mem_wdata` out 32: full word to write.
- `mem_rdata` in 32: word read data, valid combinationally while `mem_read` is high.

## Operation
- States: IDLE, READ, WRITE, RESP.
- **Accept:** in IDLE, on accept, latch we/funct3/addr/wdata, then check the request:
  - Illegal funct3: loads 3/6/7; stores anything other than 0/1/2.
  - Misaligned: H/HU/SH with `addr[0]=1`; W with `addr[1:0]≠0`.
  - If illegal or misaligned, go to RESP with the error flag set and no memory access.
- **Transitions:**
  - Load: IDLE→READ→RESP.
  - SW: IDLE→WRITE→RESP.
  - SB/SH: IDLE→READ→WRITE→RESP.
  - RESP→IDLE unconditionally.
- **READ:** `mem_read=1`. At the edge, register `mem_rdata` into the word buffer.
  - Loads: extract and extend into `rsp_rdata`.
  - Stores: merge new data into the buffer.
- **Extract (little-endian):**
  - Byte lane k = bits [8k+7:8k], with k = `addr[1:0]`.
  - Half lane = bits [16h+15:16h], with h = `addr[1]`.
  - B/H sign-extend; BU/HU zero-extend; W passes through.
- **Merge:** replace only the addressed byte or half lane of the read word with `req_wdata[7:0]` or `req_wdata[15:0]`. All other lanes are bit-exact preserved.
- **WRITE:** `mem_write=1`; `mem_wdata` is the registered merged word, or the latched `req_wdata` for SW.
- **Strobes:** `mem_read` and `mem_write` are decoded from the state register only. They are never both high. Both are 0 in IDLE and RESP.
- **RESP:** `rsp_valid=1` for exactly one cycle. There is no response backpressure.
- **Reset values:** `req_ready=1`, `rsp_valid=0`, `rsp_rdata=0`, `rsp_err=0`, `mem_read=0`, `mem_write=0`, `mem_addr=0`, `mem_wdata=0`, state = IDLE.
- **Reset mid-operation:** state returns to IDLE immediately and the strobes drop combinationally. A WRITE cycle interrupted before its edge performs no write. No response is produced for the aborted request.

## Timing
- Latency is counted from the accept edge to the cycle in which `rsp_valid` is high:
  - Load: 2.
  - SW: 2.
  - SB/SH: 3.
  - Error: 1.
- `req_ready` is low from the cycle after accept through RESP. The next request can be accepted on the edge that ends RESP+1 (IDLE), so throughput is one access per latency+1 cycles.
- `mem_addr` is stable from READ through the end of WRITE. Request inputs are not sampled after accept.
- `rsp_rdata` and `rsp_err` are registered and valid only in the RESP cycle. They hold their value otherwise and are cleared only by reset.

## Structure
- Package `lsu_pkg`:
  - funct3 constants (`F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`).
  - FSM state enum (IDLE/READ/WRITE/RESP).
- One combinational sub-module, `lsu_align`:
  - Inputs: funct3, `addr[1:0]`, read word, store data.
  - Outputs: extended load value, merged store word, misaligned/illegal flag.
- Top level: FSM, request latches, word buffer, response registers.

## Test plan
- **Word round-trip:** SW addr 0x10, data 0xDEADBEEF, then LW 0x10 → write of 0xDEADBEEF to word address 0x10; `rsp_rdata=0xDEADBEEF` 2 cycles after the load accept; `rsp_err=0`.
- **Byte RMW:** memory word at 0x20 = 0x11223344; SB addr 0x22, data 0x000000AA → memory reads 0x11AA3344; exactly one `mem_read` cycle then one `mem_write` cycle; `rsp_valid` 3 cycles after accept.
- **Extension:** word 0x8081F0F1 at 0x30:
  - LB 0x30 → 0xFFFFFFF1.
  - LBU 0x33 → 0x00000080.
  - LH 0x32 → 0xFFFF8081.
  - LHU 0x30 → 0x0000F0F1.
- **Errors:** LW 0x41, SH 0x43, funct3=3 load → each gives `rsp_err=1` and `rsp_rdata=0` 1 cycle after accept; `mem_read` and `mem_write` never assert.
- **Handshake:** `req_valid` held high continuously across back-to-back loads → `req_ready=0` from accept until IDLE; each request is accepted exactly once; `rsp_valid` is a single-cycle pulse per request.
- **Reset during WRITE:** assert `rst_n=0` mid-WRITE of an SH → `mem_write` drops immediately; memory word unchanged; all outputs at reset values; `req_ready=1` once `rst_n` is released.
